// File: rtl/count_seq_monitor.sv
// Sequence checker for a free-running mod-(MAX_COUNT+1) counter: locks on the first 0, tracks
// the expected next value, counts legal wraps and captures the first violation.
module count_seq_monitor #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned MAX_COUNT  = 13,
  parameter int unsigned WRAP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      count_in,
  input  logic                  clr,
  output logic                  locked,
  output logic                  wrap_pulse,
  output logic [WRAP_CNT_W-1:0] wrap_cnt,
  output logic                  err,
  output logic [WIDTH-1:0]      err_expected,
  output logic [WIDTH-1:0]      err_actual
);

  typedef enum logic [1:0] {
    StSync  = 2'b00,
    StTrack = 2'b01,
    StError = 2'b10
  } state_e;

  localparam logic [WIDTH:0] MaxExt = (WIDTH+1)'(MAX_COUNT);

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      expected_q, expected_d;
  logic                  locked_q, locked_d;
  logic                  wrap_pulse_q, wrap_pulse_d;
  logic [WRAP_CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic                  err_q, err_d;
  logic [WIDTH-1:0]      err_expected_q, err_expected_d;
  logic [WIDTH-1:0]      err_actual_q, err_actual_d;
  logic [WIDTH:0]        count_inc;

  // One extra bit so the increment of the top value cannot overflow.
  assign count_inc = {1'b0, count_in} + 1'b1;

  always_comb begin
    state_d        = state_q;
    expected_d     = expected_q;
    wrap_pulse_d   = 1'b0;
    wrap_cnt_d     = wrap_cnt_q;
    err_d          = err_q;
    err_expected_d = err_expected_q;
    err_actual_d   = err_actual_q;

    if (clr) begin
      state_d        = StSync;
      expected_d     = '0;
      wrap_cnt_d     = '0;
      err_d          = 1'b0;
      err_expected_d = '0;
      err_actual_d   = '0;
    end else begin
      case (state_q)
        StSync: begin
          if (count_in == '0) begin
            state_d    = StTrack;
            expected_d = WIDTH'(1);
          end
        end
        StTrack: begin
          if (count_in == expected_q) begin
            expected_d = (count_inc > MaxExt) ? '0 : count_inc[WIDTH-1:0];
            if (count_in == '0) begin
              wrap_pulse_d = 1'b1;
              if (wrap_cnt_q != '1) wrap_cnt_d = wrap_cnt_q + 1'b1;
            end
          end else begin
            state_d        = StError;
            err_d          = 1'b1;
            err_expected_d = expected_q;
            err_actual_d   = count_in;
          end
        end
        StError: ;
        default: begin
          state_d    = StSync;
          expected_d = '0;
        end
      endcase
    end

    locked_d = (state_d == StTrack);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StSync;
      expected_q     <= '0;
      locked_q       <= 1'b0;
      wrap_pulse_q   <= 1'b0;
      wrap_cnt_q     <= '0;
      err_q          <= 1'b0;
      err_expected_q <= '0;
      err_actual_q   <= '0;
    end else begin
      state_q        <= state_d;
      expected_q     <= expected_d;
      locked_q       <= locked_d;
      wrap_pulse_q   <= wrap_pulse_d;
      wrap_cnt_q     <= wrap_cnt_d;
      err_q          <= err_d;
      err_expected_q <= err_expected_d;
      err_actual_q   <= err_actual_d;
    end
  end

  assign locked       = locked_q;
  assign wrap_pulse   = wrap_pulse_q;
  assign wrap_cnt     = wrap_cnt_q;
  assign err          = err_q;
  assign err_expected = err_expected_q;
  assign err_actual   = err_actual_q;

endmodule

// File: tb/tb_count_seq_monitor.sv
// Self-checking bench for count_seq_monitor: a behavioural model feeds a scoreboard queue,
// plus targeted checks per scenario. A second instance with a 2-bit wrap counter covers saturation.
module tb_count_seq_monitor;

  localparam int unsigned MaxC = 13;

  typedef struct packed {
    logic       locked;
    logic       pulse;
    logic [7:0] cnt;
    logic       err;
    logic [3:0] ee;
    logic [3:0] ea;
    logic [1:0] cnt2;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] count_in = 4'd0;

  logic       locked, wrap_pulse, err;
  logic [7:0] wrap_cnt;
  logic [3:0] err_expected, err_actual;
  logic       locked2, wrap_pulse2, err2;
  logic [1:0] wrap_cnt2;
  logic [3:0] err_expected2, err_actual2;

  int n_vec = 0;
  int n_err = 0;
  exp_t sb_q[$];

  int         m_state;
  logic [3:0] m_exp, m_ee, m_ea;
  logic       m_pulse, m_err, m_locked;
  logic [7:0] m_cnt;
  logic [1:0] m_cnt2;

  always #5 clk = ~clk;

  count_seq_monitor #(.WIDTH(4), .MAX_COUNT(MaxC), .WRAP_CNT_W(8)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .count_in     (count_in),
    .clr          (clr),
    .locked       (locked),
    .wrap_pulse   (wrap_pulse),
    .wrap_cnt     (wrap_cnt),
    .err          (err),
    .err_expected (err_expected),
    .err_actual   (err_actual)
  );

  count_seq_monitor #(.WIDTH(4), .MAX_COUNT(MaxC), .WRAP_CNT_W(2)) u_dut_sat (
    .clk          (clk),
    .rst          (rst),
    .count_in     (count_in),
    .clr          (clr),
    .locked       (locked2),
    .wrap_pulse   (wrap_pulse2),
    .wrap_cnt     (wrap_cnt2),
    .err          (err2),
    .err_expected (err_expected2),
    .err_actual   (err_actual2)
  );

  function automatic void model_clear();
    m_state  = 0;
    m_exp    = 4'd0;
    m_pulse  = 1'b0;
    m_locked = 1'b0;
    m_cnt    = 8'd0;
    m_cnt2   = 2'd0;
    m_err    = 1'b0;
    m_ee     = 4'd0;
    m_ea     = 4'd0;
  endfunction

  function automatic void model_step(input logic [3:0] v, input logic c);
    m_pulse = 1'b0;
    if (c) begin
      model_clear();
    end else if (m_state == 0) begin
      if (v == 4'd0) begin
        m_state = 1;
        m_exp   = 4'd1;
      end
    end else if (m_state == 1) begin
      if (v == m_exp) begin
        m_exp = (v == 4'(MaxC)) ? 4'd0 : v + 4'd1;
        if (v == 4'd0) begin
          m_pulse = 1'b1;
          if (m_cnt != 8'hff) m_cnt = m_cnt + 8'd1;
          if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
        end
      end else begin
        m_state = 2;
        m_err   = 1'b1;
        m_ee    = m_exp;
        m_ea    = v;
      end
    end
    m_locked = (m_state == 1);
  endfunction

  // Drive one sample, push the model's prediction, compare after the edge.
  task automatic step(input logic [3:0] v, input logic c);
    exp_t e;
    exp_t a;
    count_in = v;
    clr      = c;
    model_step(v, c);
    e = {m_locked, m_pulse, m_cnt, m_err, m_ee, m_ea, m_cnt2};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    a = {locked, wrap_pulse, wrap_cnt, err, err_expected, err_actual, wrap_cnt2};
    e = sb_q.pop_front();
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL sb in=%0d clr=%0b: got %h expected %h", v, c, a, e);
    end
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst      = 1'b0;
    count_in = 4'd5;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({locked, wrap_pulse, wrap_cnt, err, err_expected, err_actual} !== 19'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected 0",
               {locked, wrap_pulse, wrap_cnt, err, err_expected, err_actual});
    end
    #2 rst = 1'b1;
    step(4'd5, 1'b0);
    step(4'd6, 1'b0);
    step(4'd7, 1'b0);
    n_vec++;
    if (locked !== 1'b0) begin
      n_err++;
      $display("FAIL prelock_locked: got %0b expected 0", locked);
    end
    step(4'd0, 1'b0);
    n_vec++;
    if ({locked, wrap_pulse, wrap_cnt} !== {1'b1, 1'b0, 8'd0}) begin
      n_err++;
      $display("FAIL lock_on: got locked=%0b pulse=%0b cnt=%0d expected 1 0 0",
               locked, wrap_pulse, wrap_cnt);
    end
  endtask

  task automatic test_nominal();
    int pulses = 0;
    logic prev = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 1; i <= 14; i++) begin
        step((i == 14) ? 4'd0 : 4'(i), 1'b0);
        if (wrap_pulse === 1'b1) pulses++;
        n_vec++;
        if ((wrap_pulse === 1'b1) !== (i == 14) || (prev && wrap_pulse)) begin
          n_err++;
          $display("FAIL nominal_pulse i=%0d: got %0b expected %0b", i, wrap_pulse, i == 14);
        end
        prev = wrap_pulse;
      end
    end
    n_vec++;
    if (pulses != 2 || wrap_cnt !== 8'd2 || err !== 1'b0 || locked !== 1'b1) begin
      n_err++;
      $display("FAIL nominal_end: got pulses=%0d cnt=%0d err=%0b locked=%0b expected 2 2 0 1",
               pulses, wrap_cnt, err, locked);
    end
  endtask

  task automatic test_skip();
    step(4'd0, 1'b1);
    step(4'd0, 1'b0);
    step(4'd1, 1'b0);
    step(4'd2, 1'b0);
    step(4'd4, 1'b0);
    n_vec++;
    if ({err, err_expected, err_actual, locked} !== {1'b1, 4'd3, 4'd4, 1'b0}) begin
      n_err++;
      $display("FAIL skip_capture: got err=%0b exp=%0d act=%0d locked=%0b expected 1 3 4 0",
               err, err_expected, err_actual, locked);
    end
    step(4'd5, 1'b0);
    step(4'd6, 1'b0);
    step(4'd0, 1'b0);
    n_vec++;
    if ({err, err_expected, err_actual, wrap_pulse} !== {1'b1, 4'd3, 4'd4, 1'b0}) begin
      n_err++;
      $display("FAIL skip_hold: got err=%0b exp=%0d act=%0d pulse=%0b expected 1 3 4 0",
               err, err_expected, err_actual, wrap_pulse);
    end
  endtask

  task automatic test_early_wrap();
    step(4'd0, 1'b1);
    step(4'd0, 1'b0);
    for (int i = 1; i <= 12; i++) step(4'(i), 1'b0);
    step(4'd0, 1'b0);
    n_vec++;
    if ({err, err_expected, err_actual, wrap_pulse} !== {1'b1, 4'd13, 4'd0, 1'b0}) begin
      n_err++;
      $display("FAIL early_wrap: got err=%0b exp=%0d act=%0d pulse=%0b expected 1 13 0 0",
               err, err_expected, err_actual, wrap_pulse);
    end
    step(4'd0, 1'b1);
    step(4'd0, 1'b0);
    for (int i = 1; i <= 13; i++) step(4'(i), 1'b0);
    step(4'd13, 1'b0);
    n_vec++;
    if ({err, err_expected, err_actual} !== {1'b1, 4'd0, 4'd13}) begin
      n_err++;
      $display("FAIL stuck_max: got err=%0b exp=%0d act=%0d expected 1 0 13",
               err, err_expected, err_actual);
    end
    step(4'd0, 1'b1);
    step(4'd0, 1'b0);
    step(4'd0, 1'b0);
    n_vec++;
    if ({err, err_expected, err_actual} !== {1'b1, 4'd1, 4'd0}) begin
      n_err++;
      $display("FAIL stuck_zero: got err=%0b exp=%0d act=%0d expected 1 1 0",
               err, err_expected, err_actual);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] want [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    int pulses = 0;
    step(4'd0, 1'b1);
    step(4'd0, 1'b0);
    for (int r = 0; r < 5; r++) begin
      for (int i = 1; i <= 13; i++) step(4'(i), 1'b0);
      step(4'd0, 1'b0);
      if (wrap_pulse2 === 1'b1) pulses++;
      n_vec++;
      if (wrap_cnt2 !== want[r]) begin
        n_err++;
        $display("FAIL sat_cnt wrap=%0d: got %0d expected %0d", r, wrap_cnt2, want[r]);
      end
    end
    n_vec++;
    if (pulses != 5 || wrap_cnt !== 8'd5) begin
      n_err++;
      $display("FAIL sat_pulses: got pulses=%0d cnt=%0d expected 5 5", pulses, wrap_cnt);
    end
  endtask

  task automatic test_clear();
    step(4'd7, 1'b0);
    step(4'd3, 1'b1);
    n_vec++;
    if ({err, err_expected, err_actual, wrap_cnt, locked} !== 18'd0) begin
      n_err++;
      $display("FAIL clr_error: got err=%0b exp=%0d act=%0d cnt=%0d locked=%0b expected 0",
               err, err_expected, err_actual, wrap_cnt, locked);
    end
    step(4'd0, 1'b0);
    for (int i = 1; i <= 13; i++) step(4'(i), 1'b0);
    step(4'd0, 1'b0);
    n_vec++;
    if ({locked, wrap_pulse, wrap_cnt} !== {1'b1, 1'b1, 8'd1}) begin
      n_err++;
      $display("FAIL relock: got locked=%0b pulse=%0b cnt=%0d expected 1 1 1",
               locked, wrap_pulse, wrap_cnt);
    end
    #2 rst = 1'b0;
    #1;
    model_clear();
    n_vec++;
    if ({locked, wrap_pulse, wrap_cnt, err, err_expected, err_actual} !== 19'd0) begin
      n_err++;
      $display("FAIL async_reset: got %h expected 0",
               {locked, wrap_pulse, wrap_cnt, err, err_expected, err_actual});
    end
    #2 rst = 1'b1;
    step(4'd0, 1'b0);
    step(4'd9, 1'b1);
    n_vec++;
    if ({err, locked} !== 2'b00) begin
      n_err++;
      $display("FAIL clr_vs_mismatch: got err=%0b locked=%0b expected 0 0", err, locked);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_skip();
    test_early_wrap();
    test_saturation();
    test_clear();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/count_seq_monitor.md
Name: count_seq_monitor

Overview:
Downstream checker for the free-running mod-(MAX_COUNT+1) counter (0..13 by default). It samples the counter value every cycle and locks onto the sequence at the first 0. It then tracks the expected next value, pulses and counts on each legal wrap MAX_COUNT->0, and flags and captures the first sequence violation. It sits directly on the counter's Q output and feeds status to the control/debug logic.

Parameters:
WIDTH, 4, width of count_in and of the captured values.
MAX_COUNT, 13, terminal count of the monitored counter; legal range 1..2^WIDTH-1.
WRAP_CNT_W, 8, width of the saturating wrap counter.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-low reset.
count_in  input  WIDTH  counter value being monitored, sampled every rising edge.
clr  input  1  synchronous clear; returns the block to SYNC and zeroes all status.
locked  output  1  high while in TRACK.
wrap_pulse  output  1  one-cycle pulse per legal wrap.
wrap_cnt  output  WRAP_CNT_W  number of legal wraps since reset/clr; saturates at all-ones.
err  output  1  sticky sequence-violation flag.
err_expected  output  WIDTH  expected value at the first violation.
err_actual  output  WIDTH  sampled value at the first violation.

Behaviour:
- All outputs are registered. Each response appears in the cycle after the edge that samples the causing count_in.
- Reset (rst=0, asynchronous): state=SYNC, expected=0. All outputs are 0: locked, wrap_pulse, wrap_cnt, err, err_expected, err_actual. Reset asserted mid-operation discards all state immediately.
- Priority on each edge: clr, then the state action.
- clr=1: same end values as reset (state SYNC), applied at the edge. This holds in every state, including ERROR and TRACK.
- SYNC:
  - count_in==0 -> TRACK, expected=1.
  - Any other value, including values >MAX_COUNT -> stay in SYNC.
  - The lock-on 0 is not a wrap: no pulse, wrap_cnt unchanged.
- TRACK, count_in==expected:
  - Next expected = 0 if count_in==MAX_COUNT, else count_in+1, computed at WIDTH+1 bits with no overflow.
  - If count_in==0 (a completed wrap): wrap_pulse=1 for one cycle, and wrap_cnt+1 unless already all-ones.
- TRACK, count_in!=expected:
  - -> ERROR, err=1, err_expected=expected, err_actual=count_in.
  - No pulse, wrap_cnt frozen.
- ERROR:
  - err, captures and wrap_cnt hold; locked=0, wrap_pulse=0.
  - count_in is ignored. The only exits are clr and reset; there is no automatic re-sync.
- wrap_pulse is never high for two consecutive cycles (MAX_COUNT>=1).
- A counter held in reset (count_in stuck at 0) while the monitor is in TRACK is a violation: expected 1, actual 0. A stuck value at MAX_COUNT likewise yields expected 0, actual MAX_COUNT.
- States use 2-bit encoding: SYNC, TRACK, ERROR. The unused encoding goes to SYNC on the next edge.

Test Plan:
1. Reset/lock: rst=0 with count_in=5 -> all outputs 0. Release, drive 5,6,7 -> locked=0. Drive 0 -> locked=1 next cycle, wrap_pulse=0, wrap_cnt=0.
2. Nominal: after lock, drive 1..13,0,1..13,0 -> exactly two single-cycle wrap_pulse, each the cycle after a 0 is sampled. Final wrap_cnt=2, err=0, locked=1.
3. Skip: locked, drive 0,1,2,4 -> cycle after 4 is sampled: err=1, err_expected=3, err_actual=4, locked=0. Further values 5,6,0 leave all captures unchanged.
4. Early wrap / stuck: drive ...,11,12,0 -> err=1, err_expected=13, err_actual=0, no pulse. A separate run drives 13,13 -> err_expected=0, err_actual=13.
5. Saturation: WRAP_CNT_W=2, five full wraps -> wrap_cnt sequence 1,2,3,3,3, with five wrap_pulses still seen.
6. Clear/reset mid-operation:
   - clr=1 in ERROR -> next cycle err=0, captures 0, wrap_cnt=0, SYNC; drive 0 -> relocks.
   - rst low mid-TRACK between edges -> outputs 0 immediately, without waiting for clk.
   - clr together with a mismatch -> clr wins, err stays 0.
